// File: rtl/bpu_pkg.sv
// Shared BPU definitions: counter encodings, FSM state encoding and the
// saturating counter next-state function.
package bpu_pkg;

    // Two-bit direction counter states
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Value written to every entry by the initialisation sweep
    localparam logic [1:0] CNT_INIT = WNT;

    typedef enum logic {
        StInit,
        StRun
    } bht_state_e;

    // Increment on taken, decrement on not-taken, saturating at both ends
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) res = cnt + 2'd1;
        end else begin
            if (cnt != SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_sat_next.sv
// Combinational next-state for one two-bit saturating direction counter.
module bht_sat_next
    import bpu_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    assign cnt_next = sat_next(cnt, taken);

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: 2^INDEX_W two-bit counters, one predict
// lookup and one resolution update per cycle, with an init sweep after reset
// and after a flush.
module bht_ctrl
    import bpu_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned PC_W    = 64
) (
    input  logic            in_Clk,
    input  logic            in_Rst_N,
    input  logic            in_pred_valid,
    input  logic [PC_W-1:0] in_pred_pc,
    output logic            out_pred_valid,
    output logic            out_pred_taken,
    input  logic            in_upd_valid,
    input  logic [PC_W-1:0] in_upd_pc,
    input  logic            in_upd_taken,
    input  logic            in_flush,
    output logic            out_busy
);

    localparam int unsigned          Entries = 2 ** INDEX_W;
    localparam logic [INDEX_W-1:0]   PtrLast = '1;

    bht_state_e         state_q;
    logic [INDEX_W-1:0] ptr_q;
    logic               pred_valid_q;
    logic               pred_taken_q;
    logic               pred_taken_d;

    logic [1:0]         bht_mem [Entries];

    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic [1:0]         rd_cnt;
    logic [1:0]         upd_cnt;
    logic [1:0]         upd_next;
    logic               upd_fire;
    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    logic [1:0]         wr_data;

    // Instructions are word aligned; the low two bits and the tag bits are ignored
    assign pred_idx = in_pred_pc[INDEX_W+1:2];
    assign upd_idx  = in_upd_pc[INDEX_W+1:2];

    logic unused_pc;
    assign unused_pc = ^{in_pred_pc[PC_W-1:INDEX_W+2], in_pred_pc[1:0],
                         in_upd_pc[PC_W-1:INDEX_W+2], in_upd_pc[1:0]};

    assign rd_cnt  = bht_mem[pred_idx];
    assign upd_cnt = bht_mem[upd_idx];

    // Shared by the write path and the same-index bypass
    bht_sat_next u_sat_next (
        .cnt      (upd_cnt),
        .taken    (in_upd_taken),
        .cnt_next (upd_next)
    );

    // A flush takes priority over an update arriving in the same cycle
    assign upd_fire = (state_q == StRun) && in_upd_valid && !in_flush;

    // Table write source: sweep pointer during init, update RMW during run
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_data = upd_next;
        if (state_q == StInit) begin
            wr_en   = 1'b1;
            wr_idx  = ptr_q;
            wr_data = CNT_INIT;
        end else if (upd_fire) begin
            wr_en = 1'b1;
        end
    end

    // Prediction direction, forwarding a same-cycle update to the same entry
    always_comb begin
        pred_taken_d = 1'b0;
        if (state_q == StRun) begin
            if (upd_fire && (upd_idx == pred_idx)) begin
                pred_taken_d = upd_next[1];
            end else begin
                pred_taken_d = rd_cnt[1];
            end
        end
    end

    // Counter storage; deliberately unreset, the sweep defines its contents
    always_ff @(posedge in_Clk) begin
        if (wr_en) begin
            bht_mem[wr_idx] <= wr_data;
        end
    end

    // Init/run sequencing, sweep pointer and registered prediction outputs
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            state_q      <= StInit;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= in_pred_valid;
            pred_taken_q <= in_pred_valid && pred_taken_d;
            unique case (state_q)
                StInit: begin
                    if (in_flush) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == PtrLast) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (in_flush) begin
                        state_q <= StInit;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StInit;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign out_busy       = (state_q == StInit);
    assign out_pred_valid = pred_valid_q;
    assign out_pred_taken = pred_taken_q;

endmodule
